// File: rtl/timer_pkg.sv
// Shared constants, helpers and the alarm-mode type for the tick cascade.
package timer_pkg;

  localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
  localparam int unsigned BASE_HZ_DEFAULT = 1000;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } alarm_mode_e;

  // Ceiling log2; 0 for values 0 and 1
  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with a registered terminal-count flag.
module mod_counter
  import timer_pkg::*;
#(
  parameter  int unsigned MOD = 10,
  localparam int unsigned W   = max_u(1, clog2_u(MOD))
) (
  input  logic         clk,
  input  logic         async_nreset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_next;

  // Next count: clear wins, otherwise wrap at the terminal value
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = at_max ? '0 : cnt + W'(1);
    end
  end

  // Count register; at_max tracks cnt == MOD-1 so it is true from reset when MOD is 1
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt    <= '0;
      at_max <= (LAST == '0);
    end else begin
      cnt    <= cnt_next;
      at_max <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/timer_cascade.sv
// Prescaler plus mod-RATIO stage chain producing coincident tick strobes,
// with a countdown alarm that runs on any selected tick.
module timer_cascade
  import timer_pkg::*;
#(
  parameter  int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter  int unsigned BASE_HZ    = BASE_HZ_DEFAULT,
  parameter  int unsigned RATIO      = 10,
  parameter  int unsigned NUM_STAGES = 4,
  parameter  int unsigned ALARM_W    = 16,
  localparam int unsigned BASE_DIV   = CLK_HZ / BASE_HZ,
  localparam int unsigned SEL_W      = max_u(1, clog2_u(NUM_STAGES))
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  input  logic                  enable,
  input  logic                  clear,
  output logic [NUM_STAGES-1:0] tick,
  input  logic                  alarm_load,
  input  logic [ALARM_W-1:0]    alarm_value,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  alarm_periodic,
  output logic                  alarm_pulse,
  output logic                  alarm_active,
  output logic [ALARM_W-1:0]    alarm_count
);

  localparam int unsigned      BASE_W  = max_u(1, clog2_u(BASE_DIV));
  localparam int unsigned      CNT_W   = max_u(1, clog2_u(RATIO));
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_STAGES - 1);

  // Reject parameter sets the cascade cannot honour
  if (CLK_HZ % BASE_HZ != 0) begin : g_bad_base
    $error("timer_cascade: CLK_HZ must be an integer multiple of BASE_HZ");
  end
  if (RATIO < 2) begin : g_bad_ratio
    $error("timer_cascade: RATIO must be at least 2");
  end
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("timer_cascade: NUM_STAGES must be at least 1");
  end

  logic                  run_c;
  logic [BASE_W-1:0]     base_cnt;
  logic                  unused_base_cnt;
  logic [NUM_STAGES-1:0] stage_at_max;

  assign run_c           = enable && !clear;
  assign unused_base_cnt = ^base_cnt;

  mod_counter #(
    .MOD (BASE_DIV)
  ) u_prescaler (
    .clk          (clk),
    .async_nreset (async_nreset),
    .inc          (run_c),
    .clr          (clear),
    .cnt          (base_cnt),
    .at_max       (stage_at_max[0])
  );

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    logic [CNT_W-1:0] cnt;
    logic             unused_cnt;

    assign unused_cnt = ^cnt;

    mod_counter #(
      .MOD (RATIO)
    ) u_stage (
      .clk          (clk),
      .async_nreset (async_nreset),
      .inc          (tick[k-1]),
      .clr          (clear),
      .cnt          (cnt),
      .at_max       (stage_at_max[k])
    );
  end

  // Tick k fires when the base and all stages up to k sit at their terminal values
  always_comb begin
    logic chain;
    chain = run_c;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      chain   = chain && stage_at_max[k];
      tick[k] = chain;
    end
  end

  logic [SEL_W-1:0]   sel_l, sel_d;
  alarm_mode_e        mode_l, mode_d;
  logic [ALARM_W-1:0] reload_l, reload_d;
  logic [ALARM_W-1:0] count_d;
  logic               active_d;
  logic               pulse_d;
  logic [SEL_W-1:0]   sel_idx_c;
  logic               tick_sel_c;

  // Clamp the latched selector and pick the tick the alarm counts on
  always_comb begin
    sel_idx_c = sel_l;
    if (32'(sel_l) >= NUM_STAGES) begin
      sel_idx_c = SEL_MAX;
    end
    tick_sel_c = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (32'(sel_idx_c) == k) begin
        tick_sel_c = tick[k];
      end
    end
  end

  // Alarm next state: clear, then load/disarm, then countdown on the selected tick
  always_comb begin
    sel_d    = sel_l;
    mode_d   = mode_l;
    reload_d = reload_l;
    count_d  = alarm_count;
    active_d = alarm_active;
    pulse_d  = 1'b0;
    if (clear) begin
      active_d = 1'b0;
      count_d  = '0;
    end else if (alarm_load) begin
      if (alarm_value != '0) begin
        sel_d    = alarm_sel;
        mode_d   = alarm_periodic ? PERIODIC : ONE_SHOT;
        reload_d = alarm_value;
        count_d  = alarm_value;
        active_d = 1'b1;
      end else begin
        active_d = 1'b0;
        count_d  = '0;
      end
    end else if (alarm_active && tick_sel_c) begin
      if (alarm_count > ALARM_W'(1)) begin
        count_d = alarm_count - ALARM_W'(1);
      end else if (alarm_count == ALARM_W'(1)) begin
        pulse_d = 1'b1;
        if (mode_l == PERIODIC) begin
          count_d = reload_l;
        end else begin
          count_d  = '0;
          active_d = 1'b0;
        end
      end
    end
  end

  // Alarm state and registered outputs
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sel_l        <= '0;
      mode_l       <= ONE_SHOT;
      reload_l     <= '0;
      alarm_count  <= '0;
      alarm_active <= 1'b0;
      alarm_pulse  <= 1'b0;
    end else begin
      sel_l        <= sel_d;
      mode_l       <= mode_d;
      reload_l     <= reload_d;
      alarm_count  <= count_d;
      alarm_active <= active_d;
      alarm_pulse  <= pulse_d;
    end
  end

endmodule

// File: tb/tb_timer_cascade.sv
// Scoreboarded bench for timer_cascade with a tick/alarm reference model.
module tb_timer_cascade;
  import timer_pkg::*;

  localparam int unsigned CLK_HZ     = 100;
  localparam int unsigned BASE_HZ    = 10;
  localparam int unsigned RATIO      = 10;
  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned ALARM_W    = 8;
  localparam int unsigned SEL_W      = 2;
  localparam int          BASE_DIV   = 10;

  logic                  clk = 1'b0;
  logic                  async_nreset = 1'b0;
  logic                  enable = 1'b0;
  logic                  clear = 1'b0;
  logic                  alarm_load = 1'b0;
  logic [ALARM_W-1:0]    alarm_value = '0;
  logic [SEL_W-1:0]      alarm_sel = '0;
  logic                  alarm_periodic = 1'b0;
  logic [NUM_STAGES-1:0] tick;
  logic                  alarm_pulse;
  logic                  alarm_active;
  logic [ALARM_W-1:0]    alarm_count;

  timer_cascade #(
    .CLK_HZ     (CLK_HZ),
    .BASE_HZ    (BASE_HZ),
    .RATIO      (RATIO),
    .NUM_STAGES (NUM_STAGES),
    .ALARM_W    (ALARM_W)
  ) dut (
    .clk            (clk),
    .async_nreset   (async_nreset),
    .enable         (enable),
    .clear          (clear),
    .tick           (tick),
    .alarm_load     (alarm_load),
    .alarm_value    (alarm_value),
    .alarm_sel      (alarm_sel),
    .alarm_periodic (alarm_periodic),
    .alarm_pulse    (alarm_pulse),
    .alarm_active   (alarm_active),
    .alarm_count    (alarm_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_STAGES-1:0] tick;
    logic                  pulse;
    logic                  active;
    logic [ALARM_W-1:0]    count;
    int                    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;
  int   cyc = 0;
  int   period[NUM_STAGES];

  // Reference model: enabled-cycle count since reset/clear plus alarm bookkeeping
  int m_elapsed;
  bit m_active, m_pulse, m_periodic;
  int m_count, m_reload, m_sel;

  task automatic model_reset();
    m_elapsed  = 0;
    m_active   = 1'b0;
    m_pulse    = 1'b0;
    m_periodic = 1'b0;
    m_count    = 0;
    m_reload   = 0;
    m_sel      = 0;
    cyc        = 0;
  endtask

  // One clock cycle of stimulus: drive, predict this cycle's outputs, advance the model
  task automatic drive_cycle(input bit en, input bit clr, input bit ld,
                             input int val, input int sel, input bit per);
    exp_t                  e;
    logic [NUM_STAGES-1:0] tk;
    @(negedge clk);
    enable         = en;
    clear          = clr;
    alarm_load     = ld;
    alarm_value    = ALARM_W'(val);
    alarm_sel      = SEL_W'(sel);
    alarm_periodic = per;
    for (int k = 0; k < NUM_STAGES; k++) begin
      tk[k] = en && !clr && (((m_elapsed + 1) % period[k]) == 0);
    end
    e.tick   = tk;
    e.pulse  = m_pulse;
    e.active = m_active;
    e.count  = ALARM_W'(m_count);
    e.cyc    = cyc;
    exp_q.push_back(e);
    checking = 1'b1;

    m_pulse = 1'b0;
    if (clr) begin
      m_active = 1'b0;
      m_count  = 0;
    end else if (ld) begin
      if (val != 0) begin
        m_reload   = val;
        m_count    = val;
        m_periodic = per;
        m_sel      = (sel > NUM_STAGES - 1) ? NUM_STAGES - 1 : sel;
        m_active   = 1'b1;
      end else begin
        m_active = 1'b0;
        m_count  = 0;
      end
    end else if (m_active && tk[m_sel]) begin
      if (m_count > 1) begin
        m_count = m_count - 1;
      end else if (m_count == 1) begin
        m_pulse = 1'b1;
        if (m_periodic) begin
          m_count = m_reload;
        end else begin
          m_count  = 0;
          m_active = 1'b0;
        end
      end
    end
    if (clr) m_elapsed = 0;
    else if (en) m_elapsed = (m_elapsed + 1) % period[NUM_STAGES-1];
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if (tick !== '0 || alarm_pulse !== 1'b0 || alarm_active !== 1'b0 || alarm_count !== '0) begin
      n_bad++;
      $display("FAIL %s: got tick=%b pulse=%b active=%b count=%0d, expected all zero",
               name, tick, alarm_pulse, alarm_active, alarm_count);
    end
  endtask

  // Monitor: compares DUT outputs against the queued prediction every checked cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (checking) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty: got outputs with no prediction queued");
        end else begin
          e = exp_q.pop_front();
          if (tick !== e.tick || alarm_pulse !== e.pulse ||
              alarm_active !== e.active || alarm_count !== e.count) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got tick=%b pulse=%b active=%b count=%0d, expected tick=%b pulse=%b active=%b count=%0d",
                     e.cyc, tick, alarm_pulse, alarm_active, alarm_count,
                     e.tick, e.pulse, e.active, e.count);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    period[0] = BASE_DIV;
    for (int k = 1; k < NUM_STAGES; k++) period[k] = period[k-1] * RATIO;
    model_reset();

    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    async_nreset = 1'b1;

    // One-shot on tick[0], then free run past the first tick[2]
    drive_cycle(1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
    idle(1100);

    // Periodic on tick[1], disarmed by a zero load partway through
    drive_cycle(1'b1, 1'b0, 1'b1, 2, 1, 1'b1);
    idle(249);
    drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    idle(300);

    // Pause for five cycles
    idle(9);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(20);

    // Synchronous clear with an armed alarm
    drive_cycle(1'b1, 1'b0, 1'b1, 4, 0, 1'b1);
    idle(15);
    drive_cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(120);

    // Load landing on a tick[0] cycle
    while (((m_elapsed + 1) % BASE_DIV) != 0) idle(1);
    drive_cycle(1'b1, 1'b0, 1'b1, 2, 0, 1'b0);
    idle(40);

    // Out-of-range selector behaves as the slowest tick
    drive_cycle(1'b1, 1'b0, 1'b1, 1, 3, 1'b1);
    idle(2100);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit en, clr, ld, per;
      int val, sel;
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 29) == 0);
      val = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      sel = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      per = 1'($urandom_range(0, 1));
      drive_cycle(en, clr, ld, val, sel, per);
    end

    // Asynchronous reset in the middle of a countdown
    drive_cycle(1'b1, 1'b0, 1'b1, 5, 0, 1'b0);
    idle(23);
    @(negedge clk);
    checking = 1'b0;
    #3;
    async_nreset = 1'b0;
    #1;
    check_all_zero("async_reset_mid_countdown");
    enable     = 1'b0;
    alarm_load = 1'b0;
    clear      = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    async_nreset = 1'b1;
    model_reset();
    drive_cycle(1'b1, 1'b0, 1'b1, 2, 0, 1'b0);
    idle(60);

    @(negedge clk);
    checking = 1'b0;
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover predictions, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
